// File: rtl/reverb_tap_loader_if.sv
// Tap-load handshake between the reverb tap loader (master) and the FIR core (slave).
// The loader drives the tap word and valid; the FIR core drives ready and its done level.
interface reverb_tap_loader_if #(
  parameter int G_TAP_WIDTH = 16
);
  logic [G_TAP_WIDTH-1:0] tap_dout;
  logic                   tap_dout_valid;
  logic                   tap_dout_ready;
  logic                   tap_done_in;

  modport master (
    output tap_dout,
    output tap_dout_valid,
    input  tap_dout_ready,
    input  tap_done_in
  );

  modport slave (
    input  tap_dout,
    input  tap_dout_valid,
    output tap_dout_ready,
    output tap_done_in
  );
endinterface

// File: rtl/reverb_tap_loader.sv
// Holds the reverb impulse-response table written by the host and streams it,
// in address order, to the FIR core's tap port, then waits for the core's done level.
module reverb_tap_loader #(
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_DONE_TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       wr_en,
  input  logic [G_NUM_TAPS_LOG2-1:0] wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_error,
  reverb_tap_loader_if.master        tap
);

  localparam int                         NUM_TAPS  = 1 << G_NUM_TAPS_LOG2;
  localparam logic [G_NUM_TAPS_LOG2-1:0] LAST_ADDR = G_NUM_TAPS_LOG2'(NUM_TAPS - 1);
  localparam logic [15:0]                TMO_LAST  = 16'(G_DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_DONE,
    DONE
  } state_t;

  state_t                     state_reg;
  state_t                     state_next;
  logic [G_NUM_TAPS_LOG2-1:0] addr_reg;
  logic [G_NUM_TAPS_LOG2-1:0] addr_next;
  logic [G_NUM_TAPS_LOG2-1:0] rd_addr;
  logic [15:0]                tmo_reg;
  logic [15:0]                tmo_next;
  logic                       valid_reg;
  logic                       valid_next;
  logic                       done_reg;
  logic                       done_next;
  logic                       error_reg;
  logic                       error_next;
  logic [G_TAP_WIDTH-1:0]     dout_reg;
  logic                       load_word;
  logic                       clear_dout;
  logic                       write_ok;
  logic                       bypass;

  logic [G_TAP_WIDTH-1:0]     tap_mem [NUM_TAPS];

  assign busy                = (state_reg == STREAM) || (state_reg == WAIT_DONE);
  assign load_done           = done_reg;
  assign load_error          = error_reg;
  assign tap.tap_dout        = dout_reg;
  assign tap.tap_dout_valid  = valid_reg;

  // The table is frozen while a load is in flight so the streamed image is coherent.
  assign write_ok = wr_en && !busy;

  // A write landing on the word being fetched this edge (write together with start)
  // is forwarded so the first beat already carries the new value.
  assign bypass = write_ok && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (write_ok) begin
      tap_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      tmo_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      tmo_reg   <= tmo_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      if (clear_dout) begin
        dout_reg <= '0;
      end else if (load_word) begin
        dout_reg <= bypass ? wr_data : tap_mem[rd_addr];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    tmo_next   = tmo_reg;
    valid_next = valid_reg;
    done_next  = done_reg;
    error_next = error_reg;
    load_word  = 1'b0;
    clear_dout = 1'b0;
    rd_addr    = addr_reg + 1'b1;

    if (!enable) begin
      // Soft abort: drop the handshake and counters, keep the sticky flags.
      state_next = IDLE;
      addr_next  = '0;
      tmo_next   = '0;
      valid_next = 1'b0;
      clear_dout = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_next = STREAM;
            addr_next  = '0;
            tmo_next   = '0;
            valid_next = 1'b1;
            done_next  = 1'b0;
            error_next = 1'b0;
            load_word  = 1'b1;
            rd_addr    = '0;
          end
        end

        STREAM: begin
          if (valid_reg && tap.tap_dout_ready) begin
            addr_next = addr_reg + 1'b1;
            load_word = 1'b1;
            if (addr_reg == LAST_ADDR) begin
              valid_next = 1'b0;
              tmo_next   = '0;
              state_next = WAIT_DONE;
            end
          end
        end

        WAIT_DONE: begin
          // Done is checked first so it wins over a timeout on the same cycle.
          if (tap.tap_done_in) begin
            state_next = DONE;
            done_next  = 1'b1;
            tmo_next   = '0;
          end else if (tmo_reg == TMO_LAST) begin
            state_next = DONE;
            error_next = 1'b1;
            tmo_next   = '0;
          end else begin
            tmo_next = tmo_reg + 16'd1;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
